mem_responder: RTL and testbench

- Memory-side responder for the multicycle CPU's memory request interface (memread/memwrite, byte and word accesses).
- Serves instruction fetch (word) and lb/sb (byte) from one byte-addressable little-endian array.
- Registered read data, configurable wait states, one-cycle completion pulse.
- Sits between the address mux (PC / ALUOut) and the IR/MDR registers.

---
 rtl/mem_responder.sv | 143 ++++++++++++++
 tb/tb_mem_responder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle CPU: byte-addressable little-endian array with
// registered read data, WAIT_CYCLES wait states and a one-cycle ready pulse.
// Optional out-of-range checking (sticky err_o) is enabled by defining MEM_RANGE_CHK_EN.
module mem_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memread_i,
  input  logic              memwrite_i,
  input  logic              size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              ready_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int unsigned IdxW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              write_q;
  logic              size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              ready_q;
  logic              busy_q;

  logic [7:0] mem [DEPTH_BYTES];

  logic [ADDR_W-1:0] base_addr;
  logic [31:0]       base_wide;
  logic [IdxW-1:0]   idx0, idx1, idx2, idx3;
  logic [31:0]       rd_val;
  logic              in_range;
  logic              commit;

  always_comb begin
    // Word accesses ignore addr[1:0]; since DEPTH_BYTES is a multiple of 4 the wrapped
    // index stays aligned, so the other three lanes are formed by setting the low bits.
    base_addr = size_q ? {addr_q[ADDR_W-1:2], 2'b00} : addr_q;
    base_wide = 32'(base_addr);
    idx0      = IdxW'(base_wide % DEPTH_BYTES);
    idx1      = {idx0[IdxW-1:2], 2'b01};
    idx2      = {idx0[IdxW-1:2], 2'b10};
    idx3      = {idx0[IdxW-1:2], 2'b11};
    rd_val    = size_q ? {mem[idx3], mem[idx2], mem[idx1], mem[idx0]}
                       : {24'h0, mem[idx0]};
    commit    = (state_q == StWait) && (cnt_q == 4'd0);
  end

`ifdef MEM_RANGE_CHK_EN
  logic err_q;

  assign in_range = base_wide < DEPTH_BYTES;
  assign err_o    = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (commit && !in_range) begin
      err_q <= 1'b1;
    end
  end
`else
  assign in_range = 1'b1;
  assign err_o    = 1'b0;
`endif

  // Array is deliberately not reset; reset at the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && commit && write_q && in_range) begin
      mem[idx0] <= wdata_q[7:0];
      if (size_q) begin
        mem[idx1] <= wdata_q[15:8];
        mem[idx2] <= wdata_q[23:16];
        mem[idx3] <= wdata_q[31:24];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      size_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          ready_q <= 1'b0;
          if (memread_i || memwrite_i) begin
            write_q <= memwrite_i;
            size_q  <= size_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            cnt_q   <= 4'(WAIT_CYCLES);
            busy_q  <= 1'b1;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (!write_q) begin
              rdata_q <= in_range ? rd_val : 32'h0;
            end
            ready_q <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rdata_o = rdata_q;
  assign ready_o = ready_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: dut 0 has no wait states, dut 1 has three wait states and a
// 256-byte array. Expected read data comes from a bench-side byte model via a queue.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memread  [2];
  logic        memwrite [2];
  logic        size     [2];
  logic [9:0]  addr     [2];
  logic [31:0] wdata    [2];
  logic [31:0] rdata    [2];
  logic        ready    [2];
  logic        busy     [2];
  logic        err      [2];

  int checks = 0;
  int errors = 0;

  logic [7:0]  mdl [2][1024];
  logic [31:0] mrd [2];
  logic        merr [2];
  int          depth [2] = '{1024, 256};
  int          waits [2] = '{0, 3};
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(10), .DEPTH_BYTES(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .memread_i(memread[0]), .memwrite_i(memwrite[0]),
    .size_i(size[0]), .addr_i(addr[0]), .wdata_i(wdata[0]), .rdata_o(rdata[0]),
    .ready_o(ready[0]), .busy_o(busy[0]), .err_o(err[0])
  );

  mem_responder #(.ADDR_W(10), .DEPTH_BYTES(256), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .memread_i(memread[1]), .memwrite_i(memwrite[1]),
    .size_i(size[1]), .addr_i(addr[1]), .wdata_i(wdata[1]), .rdata_o(rdata[1]),
    .ready_o(ready[1]), .busy_o(busy[1]), .err_o(err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: update the byte model and queue the rdata expected at ready.
  task automatic model_access(input int d, input bit wr, input bit sz, input logic [9:0] a,
                              input logic [31:0] wd);
    int eff = sz ? (int'(a) / 4) * 4 : int'(a);
    int idx = eff % depth[d];
    bit skip = 1'b0;
`ifdef MEM_RANGE_CHK_EN
    if (eff >= depth[d]) begin
      merr[d] = 1'b1;
      if (!wr) mrd[d] = 32'h0;
      skip = 1'b1;
    end
`endif
    if (!skip) begin
      if (wr) begin
        mdl[d][idx] = wd[7:0];
        if (sz) begin
          mdl[d][idx+1] = wd[15:8];
          mdl[d][idx+2] = wd[23:16];
          mdl[d][idx+3] = wd[31:24];
        end
      end else if (sz) begin
        mrd[d] = {mdl[d][idx+3], mdl[d][idx+2], mdl[d][idx+1], mdl[d][idx]};
      end else begin
        mrd[d] = {24'h0, mdl[d][idx]};
      end
    end
    exp_q.push_back(mrd[d]);
  endtask

  task automatic access(input string tag, input int d, input bit rd, input bit wr,
                        input bit sz, input logic [9:0] a, input logic [31:0] wd,
                        input bit pulse_again);
    int lat = -1;
    int pulses = 0;
    int busy_cnt = 0;
    logic [31:0] exp;
    model_access(d, wr, sz, a, wd);
    @(negedge clk);
    memread[d] = rd; memwrite[d] = wr; size[d] = sz; addr[d] = a; wdata[d] = wd;
    // Negedge k lies in cycle t+k, where t is the cycle whose closing edge sampled the request.
    for (int k = 1; k <= waits[d] + 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        memread[d] = 1'b0; memwrite[d] = 1'b0;
      end
      if (pulse_again && k == 2) memread[d] = 1'b1;
      if (pulse_again && k == 3) memread[d] = 1'b0;
      if (busy[d] === 1'b1) busy_cnt++;
      if (ready[d] === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          exp = exp_q.pop_front();
          check({tag, " rdata"}, rdata[d], exp);
        end
      end
    end
    if (lat < 0) void'(exp_q.pop_front());
    check({tag, " latency"}, 32'(lat), 32'(waits[d] + 2));
    check({tag, " ready pulses"}, 32'(pulses), 32'd1);
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'(waits[d] + 2));
    check({tag, " err"}, {31'h0, err[d]}, {31'h0, merr[d]});
  endtask

  initial begin
    int seen;
    for (int d = 0; d < 2; d++) begin
      memread[d] = 1'b0; memwrite[d] = 1'b0; size[d] = 1'b0;
      addr[d] = 10'h0; wdata[d] = 32'h0; mrd[d] = 32'h0; merr[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check("reset ready", {31'h0, ready[d]}, 32'h0);
      check("reset busy", {31'h0, busy[d]}, 32'h0);
      check("reset rdata", rdata[d], 32'h0);
      check("reset err", {31'h0, err[d]}, 32'h0);
    end

    // Zero wait states: word write/read, byte read, byte overwrite, both-high request.
    access("w0 wr 010", 0, 1'b0, 1'b1, 1'b1, 10'h010, 32'hDEADBEEF, 1'b0);
    access("w0 rd 010", 0, 1'b1, 1'b0, 1'b1, 10'h010, 32'h0, 1'b0);
    access("w0 rdb 011", 0, 1'b1, 1'b0, 1'b0, 10'h011, 32'h0, 1'b0);
    access("w0 wrb 013", 0, 1'b0, 1'b1, 1'b0, 10'h013, 32'hFFFFFF5A, 1'b0);
    access("w0 rd 012u", 0, 1'b1, 1'b0, 1'b1, 10'h012, 32'h0, 1'b0);
    access("w0 both 030", 0, 1'b1, 1'b1, 1'b1, 10'h030, 32'h12345678, 1'b0);
    access("w0 rd 030", 0, 1'b1, 1'b0, 1'b1, 10'h030, 32'h0, 1'b0);
    check("w0 merged word", rdata[0], 32'h12345678);

    // Three wait states: busy window and a request pulsed while busy.
    access("w3 wr 020", 1, 1'b0, 1'b1, 1'b1, 10'h020, 32'h0BADCAFE, 1'b0);
    access("w3 rd 020 pulse", 1, 1'b1, 1'b0, 1'b1, 10'h020, 32'h0, 1'b1);
    access("w3 wr 040", 1, 1'b0, 1'b1, 1'b1, 10'h040, 32'h11223344, 1'b0);

    // Reset two cycles into a wait-stated write abandons it.
    seen = 0;
    @(negedge clk);
    memwrite[1] = 1'b1; size[1] = 1'b1; addr[1] = 10'h040; wdata[1] = 32'hCAFEF00D;
    @(negedge clk);
    memwrite[1] = 1'b0;
    if (ready[1] === 1'b1) seen++;
    @(negedge clk);
    rst = 1'b1;
    if (ready[1] === 1'b1) seen++;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", {31'h0, busy[1]}, 32'h0);
    check("abort rdata", rdata[1], 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ready[1] === 1'b1) seen++;
    end
    check("abort ready", 32'(seen), 32'd0);
    for (int d = 0; d < 2; d++) begin
      mrd[d] = 32'h0; merr[d] = 1'b0;
    end
    access("w3 rd 040", 1, 1'b1, 1'b0, 1'b1, 10'h040, 32'h0, 1'b0);
    check("abort kept old", rdata[1], 32'h11223344);

    // Out-of-range access on the 256-byte array: wraps, or flags err with the range check.
    access("oor wr 004", 1, 1'b0, 1'b1, 1'b1, 10'h004, 32'h01020304, 1'b0);
    access("oor wr 104", 1, 1'b0, 1'b1, 1'b1, 10'h104, 32'hFFFFFFFF, 1'b0);
    access("oor rd 004", 1, 1'b1, 1'b0, 1'b1, 10'h004, 32'h0, 1'b0);
    access("oor rd 104", 1, 1'b1, 1'b0, 1'b1, 10'h104, 32'h0, 1'b0);
    access("oor rdb 005", 1, 1'b1, 1'b0, 1'b0, 10'h005, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
